// File: rtl/mem_sync_top.sv
// Row-cache sync controller: per-bank tag lookup on ACT edges, victim allocation on miss,
// stall held until the data mover pulses sync. Define DDR4_EN for bank groups (bg port).
module mem_sync_top #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17,
`ifdef DDR4_EN
  localparam int BANKGROUPS = 2**BGWIDTH,
`else
  // DDR3 mode has a single bank group regardless of BGWIDTH
  localparam int BANKGROUPS = (BGWIDTH >= 0) ? 1 : 1,
`endif
  localparam int BANKSPERGROUP = 2**BAWIDTH,
  localparam int CHROWS        = 2**CHWIDTH
) (
  input  logic                                                      clk,
  input  logic                                                      reset_n,
  input  logic [BAWIDTH-1:0]                                        ba,
`ifdef DDR4_EN
  input  logic [BGWIDTH-1:0]                                        bg,
`endif
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0]   RowId,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][4:0]             BankFSM,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                  sync,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]     cRowId,
  output logic                                                      stall
);

  localparam logic [4:0] ACT_CODE = 5'b10010;

  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0] pending;

  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
    for (genvar a = 0; a < BANKSPERGROUP; a++) begin : g_bank
      logic [CHROWS-1:0]                valid_q;
      logic [CHROWS-1:0][ADDRWIDTH-1:0] tag_q;
      logic [CHWIDTH-1:0]               ptr_q;
      logic [CHWIDTH-1:0]               crow_q;
      logic [CHWIDTH-1:0]               hit_idx;
      logic                             pend_q;
      logic                             act_q;
      logic                             act_edge;
      logic                             lookup;
      logic                             hit;

      assign act_edge = (BankFSM[g][a] == ACT_CODE) && !act_q;
      assign lookup   = act_edge && !pend_q;

      // Tags are unique per bank, so lowest-index priority is only a tie-break
      always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < CHROWS; k++) begin
          if (!hit && valid_q[k] && (tag_q[k] == RowId[g][a])) begin
            hit     = 1'b1;
            hit_idx = CHWIDTH'(k);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q <= '0;
          ptr_q   <= '0;
          crow_q  <= '0;
          pend_q  <= 1'b0;
          act_q   <= 1'b0;
        end else begin
          act_q <= (BankFSM[g][a] == ACT_CODE);
          if (lookup && hit) begin
            crow_q <= hit_idx;
          end else if (lookup) begin
            valid_q[ptr_q] <= 1'b1;
            crow_q         <= ptr_q;
            ptr_q          <= ptr_q + CHWIDTH'(1);
            pend_q         <= 1'b1;
          end else if (sync[g][a] && pend_q) begin
            pend_q <= 1'b0;
          end
        end
      end

      // Tag payload needs no reset; valid_q qualifies every entry
      always_ff @(posedge clk) begin
        if (lookup && !hit) tag_q[ptr_q] <= RowId[g][a];
      end

      assign pending[g][a] = pend_q;
      assign cRowId[g][a]  = crow_q;
    end
  end

`ifdef DDR4_EN
  assign stall = pending[bg][ba];
`else
  assign stall = pending[0][ba];
`endif

endmodule

// File: tb/tb_mem_sync_top.sv
// Self-checking bench for mem_sync_top: constant vector table, test-plan sequences,
// then randomized traffic against a slot-array reference model.
module tb_mem_sync_top;
  localparam int AW = 17;
  localparam int CHW = 6;
`ifdef DDR4_EN
  localparam int NG = 4;
  localparam int OG = 1;
`else
  localparam int NG = 1;
  localparam int OG = 0;
`endif
  localparam int NB = 4;
  localparam int NBANKS = NG * NB;
  localparam int NSLOT = 64;
  localparam logic [4:0] ACT = 5'b10010;
  localparam logic [4:0] RW = 5'b01011;
  localparam logic [4:0] IDLE = 5'b00000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] ba = '0;
`ifdef DDR4_EN
  logic [1:0] bg = '0;
`endif
  logic [NG-1:0][NB-1:0][AW-1:0]  RowId = '0;
  logic [NG-1:0][NB-1:0][4:0]     BankFSM = '0;
  logic [NG-1:0][NB-1:0]          sync = '0;
  logic [NG-1:0][NB-1:0][CHW-1:0] cRowId;
  logic stall;

  int checks = 0;
  int failures = 0;
  int cur_g = 0;

  // Reference model: each bank is an array of cached rows plus a round-robin next slot
  int m_row[NBANKS][NSLOT];
  bit m_valid[NBANKS][NSLOT];
  int m_next[NBANKS];
  bit m_pend[NBANKS];
  int m_crow[NBANKS];
  bit m_prev_act[NBANKS];

  mem_sync_top dut (
    .clk(clk),
    .reset_n(reset_n),
    .ba(ba),
`ifdef DDR4_EN
    .bg(bg),
`endif
    .RowId(RowId),
    .BankFSM(BankFSM),
    .sync(sync),
    .cRowId(cRowId),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < NBANKS; b++) begin
      for (int s = 0; s < NSLOT; s++) begin
        m_valid[b][s] = 1'b0;
        m_row[b][s] = 0;
      end
      m_next[b] = 0;
      m_pend[b] = 1'b0;
      m_crow[b] = 0;
      m_prev_act[b] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int g = 0; g < NG; g++) begin
      for (int a = 0; a < NB; a++) begin
        int b = g * NB + a;
        bit is_act = (BankFSM[g][a] == ACT);
        bit was_pend = m_pend[b];
        int row = int'(RowId[g][a]);
        if (is_act && !m_prev_act[b] && !was_pend) begin
          int found = -1;
          for (int s = 0; s < NSLOT; s++)
            if (found < 0 && m_valid[b][s] && m_row[b][s] == row) found = s;
          if (found >= 0) begin
            m_crow[b] = found;
          end else begin
            m_row[b][m_next[b]] = row;
            m_valid[b][m_next[b]] = 1'b1;
            m_crow[b] = m_next[b];
            m_next[b] = (m_next[b] + 1) % NSLOT;
            m_pend[b] = 1'b1;
          end
        end
        if (sync[g][a] && was_pend) m_pend[b] = 1'b0;
        m_prev_act[b] = is_act;
      end
    end
  endfunction

  function automatic void check_model();
    chk("model_stall", int'(stall), int'(m_pend[cur_g * NB + int'(ba)]));
    for (int g = 0; g < NG; g++)
      for (int a = 0; a < NB; a++)
        chk($sformatf("model_crow_%0d_%0d", g, a), int'(cRowId[g][a]), m_crow[g * NB + a]);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_addr(int g, int a);
    ba = a[1:0];
    cur_g = g;
`ifdef DDR4_EN
    bg = g[1:0];
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_stall", int'(stall), 0);
    for (int g = 0; g < NG; g++)
      for (int a = 0; a < NB; a++)
        chk($sformatf("rst_crow_%0d_%0d", g, a), int'(cRowId[g][a]), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  fsm;
    logic [16:0] row;
    logic        sy;
    logic        exp_stall;
    logic [5:0]  exp_crow;
  } vec_t;

  vec_t vt[18];
  logic [16:0] rows[66];

  initial begin
    vt[0]  = '{ACT,  17'h1234, 1'b0, 1'b1, 6'd0};
    vt[1]  = '{ACT,  17'h1234, 1'b0, 1'b1, 6'd0};
    vt[2]  = '{RW,   17'h0,    1'b0, 1'b1, 6'd0};
    vt[3]  = '{IDLE, 17'h0,    1'b1, 1'b0, 6'd0};
    vt[4]  = '{ACT,  17'h1234, 1'b0, 1'b0, 6'd0};
    vt[5]  = '{IDLE, 17'h0,    1'b0, 1'b0, 6'd0};
    vt[6]  = '{ACT,  17'h2222, 1'b0, 1'b1, 6'd1};
    vt[7]  = '{ACT,  17'h2222, 1'b1, 1'b0, 6'd1};
    vt[8]  = '{IDLE, 17'h0,    1'b0, 1'b0, 6'd1};
    vt[9]  = '{ACT,  17'h3333, 1'b1, 1'b1, 6'd2};
    vt[10] = '{IDLE, 17'h0,    1'b0, 1'b1, 6'd2};
    vt[11] = '{ACT,  17'h4444, 1'b0, 1'b1, 6'd2};
    vt[12] = '{IDLE, 17'h0,    1'b1, 1'b0, 6'd2};
    vt[13] = '{IDLE, 17'h0,    1'b1, 1'b0, 6'd2};
    vt[14] = '{ACT,  17'h2222, 1'b1, 1'b0, 6'd1};
    vt[15] = '{ACT,  17'h4444, 1'b0, 1'b0, 6'd1};
    vt[16] = '{IDLE, 17'h0,    1'b0, 1'b0, 6'd1};
    vt[17] = '{ACT,  17'h4444, 1'b0, 1'b1, 6'd3};

    rows[0] = 17'h1234;
    for (int i = 1; i < 66; i++) begin
      bit dup;
      do begin
        rows[i] = 17'($urandom_range(0, 131071));
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (rows[j] == rows[i]) dup = 1'b1;
      end while (dup);
    end

    set_addr(0, 0);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      BankFSM[0][0] = vt[i].fsm;
      RowId[0][0] = vt[i].row;
      sync[0][0] = vt[i].sy;
      tick();
      chk($sformatf("vec%0d_stall", i), int'(stall), int'(vt[i].exp_stall));
      chk($sformatf("vec%0d_crow", i), int'(cRowId[0][0]), int'(vt[i].exp_crow));
    end
    BankFSM = '0;
    sync = '0;
    tick();

    do_reset();
    for (int i = 0; i < 64; i++) begin
      BankFSM[0][0] = ACT;
      RowId[0][0] = rows[i];
      tick();
      chk($sformatf("fill%0d_stall_hi", i), int'(stall), 1);
      chk($sformatf("fill%0d_crow", i), int'(cRowId[0][0]), i);
      sync[0][0] = 1'b1;
      tick();
      chk($sformatf("fill%0d_stall_lo", i), int'(stall), 0);
      sync[0][0] = 1'b0;
      BankFSM[0][0] = RW;
      tick();
      BankFSM[0][0] = IDLE;
      tick();
    end

    BankFSM[0][0] = ACT;
    RowId[0][0] = 17'h1234;
    tick();
    chk("rehit_crow", int'(cRowId[0][0]), 0);
    chk("rehit_stall", int'(stall), 0);
    BankFSM[0][0] = IDLE;
    tick();

    BankFSM[0][0] = ACT;
    RowId[0][0] = rows[64];
    tick();
    chk("wrap_crow", int'(cRowId[0][0]), 0);
    chk("wrap_stall", int'(stall), 1);
    BankFSM[0][0] = IDLE;
    sync[0][0] = 1'b1;
    tick();
    sync[0][0] = 1'b0;
    BankFSM[0][0] = ACT;
    RowId[0][0] = 17'h1234;
    tick();
    chk("evicted_crow", int'(cRowId[0][0]), 1);
    chk("evicted_stall", int'(stall), 1);
    BankFSM[0][0] = IDLE;
    sync[0][0] = 1'b1;
    tick();
    sync[0][0] = 1'b0;

    BankFSM[OG][2] = ACT;
    RowId[OG][2] = 17'h0777;
    tick();
    chk("indep_stall_other_addr", int'(stall), 0);
    chk("indep_crow00", int'(cRowId[0][0]), 1);
    set_addr(OG, 2);
    #1;
    chk("indep_stall_sel", int'(stall), 1);
    BankFSM[OG][2] = IDLE;
    do_reset();
    set_addr(0, 0);

    BankFSM[0][0] = ACT;
    RowId[0][0] = 17'h1234;
    tick();
    chk("post_rst_crow", int'(cRowId[0][0]), 0);
    chk("post_rst_stall", int'(stall), 1);
    BankFSM[0][0] = IDLE;
    sync[0][0] = 1'b1;
    tick();
    sync = '0;

    for (int c = 0; c < 2000; c++) begin
      for (int g = 0; g < NG; g++) begin
        for (int a = 0; a < NB; a++) begin
          int sel = $urandom_range(0, 2);
          BankFSM[g][a] = (sel == 0) ? IDLE : ((sel == 1) ? ACT : RW);
          RowId[g][a] = 17'(17'h100 + $urandom_range(0, 79));
          sync[g][a] = ($urandom_range(0, 3) == 0);
        end
      end
      set_addr($urandom_range(0, NG - 1), $urandom_range(0, NB - 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_sync_top.md
Name: mem_sync_top

Overview:
- Row-cache sync controller for the DRAM emulator.
- Each bank keeps a small cache of CHROWS row slots that mirror rows of a larger backing memory.
- On a bank ACTIVATE, the block looks up the requested row, returns the cache slot index (cRowId), and flags a miss with stall.
- stall stays high until the external data mover pulses that bank's sync.

Parameters:
- BGWIDTH, 2, bank-group address width; BANKGROUPS = 2**BGWIDTH.
- BAWIDTH, 2, bank address width; BANKSPERGROUP = 2**BAWIDTH.
- CHWIDTH, 6, cache slot index width; CHROWS = 2**CHWIDTH slots per bank.
- ADDRWIDTH, 17, DRAM row address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  reset; one clock; asynchronous, active-low.
- ba  in  BAWIDTH  bank address of current command.
- bg  in  BGWIDTH  bank-group address; present only with DDR4_EN.
- RowId  in  [BANKGROUPS][BANKSPERGROUP] x ADDRWIDTH  row requested per bank.
- BankFSM  in  [BANKGROUPS][BANKSPERGROUP] x 5  per-bank FSM state code.
- sync  in  [BANKGROUPS][BANKSPERGROUP] x 1  per-bank one-cycle "transfer done" pulse.
- cRowId  out  [BANKGROUPS][BANKSPERGROUP] x CHWIDTH  cache slot of the bank's open row.
- stall  out  1  miss pending on the addressed bank.

Behaviour:
- Per bank state:
  - tag table: CHROWS entries of {valid, ADDRWIDTH tag}.
  - victim pointer: CHWIDTH bits.
  - pending flag.
  - ACT-edge register.
- Reset (async, reset_n=0): clear all valid bits, pointers and pending flags; cRowId=0 for every bank; stall=0.
- ACT code is 5'b10010. An ACT edge is a cycle where BankFSM==ACT and the previous cycle's value was not ACT. All other codes (e.g. 5'b01011 read/write, 0 idle) cause no action.
- On an ACT edge with pending=0, compare RowId against all valid tags of that bank (parallel):
  - Hit on slot k: cRowId<=k next cycle; pending unchanged at 0.
  - Miss: slot v = victim pointer. Next cycle: tag[v]<=RowId, valid[v]<=1, cRowId<=v, pointer<=v+1 mod CHROWS (wraps 63->0), pending<=1.
- An ACT edge while pending=1 is ignored; no lookup and no allocation.
- sync pulse on a bank with pending=1 clears pending next cycle. sync with pending=0 is ignored.
- Same-cycle ACT-edge miss and sync on one bank: the allocation wins and pending=1.
- Banks operate fully independently. cRowId holds its value until the bank's next ACT edge.
- stall = pending[bg][ba], combinational mux of the registered flag. stall therefore rises one cycle after the ACT edge and falls one cycle after sync.
- A mid-operation reset drops stall immediately and invalidates all cached rows.

Optional Feature:
- DDR4_EN defined: bg port exists; BANKGROUPS = 2**BGWIDTH; bank index is {bg, ba}.
- DDR4_EN undefined (DDR3 mode):
  - no bg port; a single bank group (BANKGROUPS=1, first array dimension 1).
  - Lookup and stall use bank [0][ba] only.
  - BGWIDTH is ignored.

Test Plan:
- Reset held 1 cycle -> stall=0, all cRowId=0. First ACT on bank (0,0) with RowId=0x1234 -> miss; cRowId=0; stall=1 until a sync pulse; stall=0 one cycle after sync.
- 64 distinct random rows ACT'd on bank (0,0), each followed by sync then BankFSM=5'b01011 then 0 -> cRowId steps 0..63; stall high exactly between each ACT edge and its sync.
- Re-ACT of the first row (0x1234) after the table fills -> hit; cRowId=0; stall stays 0.
- 65th distinct row on bank (0,0) -> victim pointer wraps; cRowId=0; stall=1. Old row 0x1234 then misses again and lands in slot 1.
- Miss on bank (1,2) while bg/ba address (0,0) -> stall=0. Switch bg=1, ba=2 -> stall=1. cRowId of bank (0,0) unchanged.
- Reset_n pulsed low while stall=1 -> stall=0 immediately; subsequent ACT of a previously cached row misses at slot 0.
